ram_bist: RTL and testbench

RAM_BIST -- requirements
Module: ram_bist

---
 rtl/ram_bist_pkg.sv | 28 ++
 rtl/ram_bist_cmp.sv | 67 ++++++
 rtl/ram_bist.sv | 178 +++++++++++++++++
 tb/tb_ram_bist.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/ram_bist_pkg.sv
// Shared types and phase-length helpers for the ram_bist March-style RAM self test.
// Phase lengths are expressed in terms of the RAM depth D = 2**n1.
package ram_bist_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_W0,
        S_R0W1,
        S_R1W0,
        S_R0,
        S_DONE
    } state_t;

    // The write-only background phase takes one cycle per word.
    function automatic int w0_len(input int d);
        return d;
    endfunction

    // Read/compare phases take one extra trailing compare-only cycle.
    function automatic int rw_len(input int d);
        return d + 1;
    endfunction

    function automatic int run_len(input int d);
        return w0_len(d) + 3 * rw_len(d);
    endfunction

endpackage

// File: rtl/ram_bist_cmp.sv
// Read-data checker for ram_bist: registers the expected word and address alongside each
// read request, compares the returned data one cycle later and captures the first failure.
module ram_bist_cmp
    import ram_bist_pkg::*;
#(
    parameter int n1 = 5,
    parameter int n2 = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clear,
    input  logic          i_re,
    input  logic [n1-1:0] i_radr,
    input  logic [n2-1:0] i_exp,
    input  logic [n2-1:0] i_read,
    output logic          o_mismatch,
    output logic          o_fail,
    output logic [n1-1:0] o_fail_addr,
    output logic [n2-1:0] o_fail_data,
    output logic [n2-1:0] o_fail_exp
);

    logic          r_valid;
    logic [n1-1:0] r_addr;
    logic [n2-1:0] r_exp;
    logic          r_fail;
    logic [n1-1:0] r_fail_addr;
    logic [n2-1:0] r_fail_data;
    logic [n2-1:0] r_fail_exp;
    logic          w_mismatch;

    assign w_mismatch = r_valid && (i_read != r_exp);

    // NOTE: the capture registers are reset as well, because fail_* must read zero after reset.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_valid     <= 1'b0;
            r_addr      <= '0;
            r_exp       <= '0;
            r_fail      <= 1'b0;
            r_fail_addr <= '0;
            r_fail_data <= '0;
            r_fail_exp  <= '0;
        end else begin
            r_valid <= i_re;
            if (i_re) begin
                r_addr <= i_radr;
                r_exp  <= i_exp;
            end
            if (w_mismatch) begin
                r_fail <= 1'b1;
                if (!r_fail) begin
                    r_fail_addr <= r_addr;
                    r_fail_data <= i_read;
                    r_fail_exp  <= r_exp;
                end
            end
        end
    end

    assign o_mismatch  = w_mismatch;
    assign o_fail      = r_fail;
    assign o_fail_addr = r_fail_addr;
    assign o_fail_data = r_fail_data;
    assign o_fail_exp  = r_fail_exp;

endmodule

// File: rtl/ram_bist.sv
// March test controller (W0, R0W1 up, R1W0 down, R0 up) driving a dual-port RAM.
// Define RAM_BIST_STOP_ON_FAIL_EN to end the run on the first mismatch instead of completing it.
module ram_bist
    import ram_bist_pkg::*;
#(
    parameter int            n1  = 5,
    parameter int            n2  = 8,
    parameter logic [n2-1:0] PAT = n2'(8'h55)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          we,
    output logic [n1-1:0] WAdr,
    output logic [n2-1:0] write,
    output logic          re,
    output logic [n1-1:0] RAdr,
    input  logic [n2-1:0] read,
    output logic          busy,
    output logic          done,
    output logic          fail,
    output logic [n1-1:0] fail_addr,
    output logic [n2-1:0] fail_data,
    output logic [n2-1:0] fail_exp
);

    localparam int            D          = 1 << n1;
    localparam logic [n1:0]   C_W0_LAST  = (n1 + 1)'(w0_len(D) - 1);
    localparam logic [n1:0]   C_RW_LAST  = (n1 + 1)'(rw_len(D) - 1);
    localparam logic [n1:0]   C_RD_LAST  = (n1 + 1)'(D - 1);
    localparam logic [n1-1:0] C_ADR_MAX  = '1;
`ifdef RAM_BIST_STOP_ON_FAIL_EN
    localparam bit            C_STOP_ON_FAIL = 1'b1;
`else
    localparam bit            C_STOP_ON_FAIL = 1'b0;
`endif

    state_t        r_state;
    logic [n1:0]   r_cnt;
    logic          r_we;
    logic          r_re;
    logic [n1-1:0] r_wadr;
    logic [n1-1:0] r_radr;
    logic [n2-1:0] r_write;
    logic          r_busy;
    logic          r_done;

    logic          w_start_ok;
    logic          w_mismatch;
    logic          w_stop;
    logic [n2-1:0] w_exp;

    assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_stop     = C_STOP_ON_FAIL && r_busy && w_mismatch;
    assign w_exp      = (r_state == S_R1W0) ? ~PAT : PAT;

    // NOTE: each branch sets the outputs for the *next* cycle, so every RAM control is a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_re    <= 1'b0;
            r_wadr  <= '0;
            r_radr  <= '0;
            r_write <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else if (w_stop) begin
            r_state <= S_DONE;
            r_we    <= 1'b0;
            r_re    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state <= S_W0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_we    <= 1'b1;
                        r_re    <= 1'b0;
                        r_wadr  <= '0;
                        r_write <= PAT;
                    end
                end
                S_W0: begin
                    if (r_cnt == C_W0_LAST) begin
                        r_state <= S_R0W1;
                        r_cnt   <= '0;
                        r_we    <= 1'b0;
                        r_re    <= 1'b1;
                        r_radr  <= '0;
                    end else begin
                        r_cnt  <= r_cnt + 1'b1;
                        r_wadr <= r_wadr + 1'b1;
                    end
                end
                S_R0W1: begin
                    if (r_cnt == C_RW_LAST) begin
                        r_state <= S_R1W0;
                        r_cnt   <= '0;
                        r_we    <= 1'b0;
                        r_re    <= 1'b1;
                        r_radr  <= C_ADR_MAX;
                    end else begin
                        // Write back the word read last cycle while the next read goes out.
                        r_cnt   <= r_cnt + 1'b1;
                        r_we    <= 1'b1;
                        r_wadr  <= r_radr;
                        r_write <= ~PAT;
                        if (r_cnt == C_RD_LAST) r_re <= 1'b0;
                        else                    r_radr <= r_radr + 1'b1;
                    end
                end
                S_R1W0: begin
                    if (r_cnt == C_RW_LAST) begin
                        r_state <= S_R0;
                        r_cnt   <= '0;
                        r_we    <= 1'b0;
                        r_re    <= 1'b1;
                        r_radr  <= '0;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                        r_we    <= 1'b1;
                        r_wadr  <= r_radr;
                        r_write <= PAT;
                        if (r_cnt == C_RD_LAST) r_re <= 1'b0;
                        else                    r_radr <= r_radr - 1'b1;
                    end
                end
                S_R0: begin
                    if (r_cnt == C_RW_LAST) begin
                        r_state <= S_DONE;
                        r_we    <= 1'b0;
                        r_re    <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == C_RD_LAST) r_re <= 1'b0;
                        else                    r_radr <= r_radr + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    ram_bist_cmp #(
        .n1 (n1),
        .n2 (n2)
    ) u_cmp (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (w_start_ok),
        .i_re        (r_re),
        .i_radr      (r_radr),
        .i_exp       (w_exp),
        .i_read      (read),
        .o_mismatch  (w_mismatch),
        .o_fail      (fail),
        .o_fail_addr (fail_addr),
        .o_fail_data (fail_data),
        .o_fail_exp  (fail_exp)
    );

    assign we    = r_we;
    assign re    = r_re;
    assign WAdr  = r_wadr;
    assign RAdr  = r_radr;
    assign write = r_write;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule

// File: tb/tb_ram_bist.sv
// Directed bench for ram_bist (n1=5, n2=8): fault-free runs, a stuck-at-0 bit at address 7,
// ignored start while busy, mid-run reset. Follows RAM_BIST_STOP_ON_FAIL_EN if defined.
module tb_ram_bist;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       we;
    logic [4:0] WAdr;
    logic [7:0] write;
    logic       re;
    logic [4:0] RAdr;
    logic [7:0] read;
    logic       busy;
    logic       done;
    logic       fail;
    logic [4:0] fail_addr;
    logic [7:0] fail_data;
    logic [7:0] fail_exp;

    logic [7:0] mem [32];
    bit         fault;
    int         edges = 0;
    int         n_checks = 0;
    int         n_errors = 0;

    // Results of the most recent run
    int         lat, first_fail, mon_errs, adr_errs, pulses_after;
    logic       fail_k0;
    logic [4:0] faddr_k0;
    logic [7:0] wd_c5, wd_c40;

    always #5 clk = ~clk;

    ram_bist #(.n1(5), .n2(8), .PAT(8'h55)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .we        (we),
        .WAdr      (WAdr),
        .write     (write),
        .re        (re),
        .RAdr      (RAdr),
        .read      (read),
        .busy      (busy),
        .done      (done),
        .fail      (fail),
        .fail_addr (fail_addr),
        .fail_data (fail_data),
        .fail_exp  (fail_exp)
    );

    // Dual-port RAM with registered read; optional bit 3 of address 7 stuck at 0
    always @(posedge clk) begin
        edges <= edges + 1;
        if (we) mem[WAdr] <= (fault && WAdr == 5'd7) ? (write & 8'hF7) : write;
        if (re) read <= mem[RAdr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected RAM controls in cycle c (cycle 1 follows the edge that sampled start)
    function automatic void exp_cycle(input int c, output bit e_we, output bit e_re,
                                      output logic [4:0] e_wa, output logic [4:0] e_ra,
                                      output logic [7:0] e_wd);
        int j;
        e_we = 1'b0; e_re = 1'b0; e_wa = '0; e_ra = '0; e_wd = '0;
        if (c >= 1 && c <= 32) begin
            e_we = 1'b1; e_wa = 5'(c - 1); e_wd = 8'h55;
        end else if (c >= 33 && c <= 65) begin
            j = c - 33; e_re = (j < 32); e_ra = 5'(j);
            e_we = (j > 0); e_wa = 5'(j - 1); e_wd = 8'hAA;
        end else if (c >= 66 && c <= 98) begin
            j = c - 66; e_re = (j < 32); e_ra = 5'(31 - j);
            e_we = (j > 0); e_wa = 5'(32 - j); e_wd = 8'h55;
        end else if (c >= 99 && c <= 131) begin
            j = c - 99; e_re = (j < 32); e_ra = 5'(j);
        end
    endfunction

    task automatic run_bist(input int repulse_at, input int rst_at, input bit mon);
        int         k;
        int         t0;
        bit         e_we, e_re;
        logic [4:0] e_wa, e_ra, prev_ra;
        logic [7:0] e_wd;
        lat = -1; first_fail = -1; mon_errs = 0; adr_errs = 0; pulses_after = 0;
        prev_ra = '0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; t0 = edges;
        fail_k0 = fail; faddr_k0 = fail_addr;
        for (int n = 0; n < 300; n++) begin
            k = edges - t0;
            if (rst_at > 0 && k + 1 == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            if (done && lat < 0) lat = k;
            if (fail && first_fail < 0) first_fail = k;
            if (lat >= 0) begin
                if (we || re) pulses_after++;
                if (k >= lat + 4) break;
            end else if (mon) begin
                exp_cycle(k + 1, e_we, e_re, e_wa, e_ra, e_wd);
                if (we !== e_we || re !== e_re || busy !== 1'b1) mon_errs++;
                if (e_we && (WAdr !== e_wa || write !== e_wd)) mon_errs++;
                if (e_re && RAdr !== e_ra) mon_errs++;
                if (we && re && WAdr == RAdr) mon_errs++;
                if (k + 1 >= 67 && k + 1 <= 98 && we && WAdr !== prev_ra) adr_errs++;
            end
            if (k + 1 == 5)  wd_c5  = write;
            if (k + 1 == 40) wd_c40 = write;
            prev_ra = RAdr;
            start = (repulse_at > 0 && k + 1 == repulse_at);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic check_zero(input string ph);
        check({ph, "_we"},        32'(we),        0);
        check({ph, "_re"},        32'(re),        0);
        check({ph, "_busy"},      32'(busy),      0);
        check({ph, "_done"},      32'(done),      0);
        check({ph, "_fail"},      32'(fail),      0);
        check({ph, "_wadr"},      32'(WAdr),      0);
        check({ph, "_radr"},      32'(RAdr),      0);
        check({ph, "_write"},     32'(write),     0);
        check({ph, "_fail_addr"}, 32'(fail_addr), 0);
        check({ph, "_fail_data"}, 32'(fail_data), 0);
        check({ph, "_fail_exp"},  32'(fail_exp),  0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; fault = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
        repeat (2) @(negedge clk);
        start = 1'b1;                   // reset must override start
        @(negedge clk);
        check_zero("rst");
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check("idle_busy", 32'(busy), 0);

        // Fault-free run with a start re-pulse at cycle 50
        run_bist(50, 0, 1'b1);
        check("run1_done_lat",  32'(lat), 131);
        check("run1_fail",      32'(fail), 0);
        check("run1_seq",       32'(mon_errs), 0);
        check("run1_r1w0_adr",  32'(adr_errs), 0);
        check("run1_w0_data",   32'(wd_c5), 32'h55);
        check("run1_r0w1_data", 32'(wd_c40), 32'hAA);
        check("run1_idle_pulses", 32'(pulses_after), 0);
        check("run1_busy_end",  32'(busy), 0);

        // Stuck-at-0 on bit 3 of address 7, restarted from DONE
        fault = 1'b1;
        run_bist(0, 0, 1'b0);
        check("run2_fail",       32'(fail), 1);
        check("run2_first_fail", 32'(first_fail), 91);
        check("run2_fail_addr",  32'(fail_addr), 7);
        check("run2_fail_data",  32'(fail_data), 32'hA2);
        check("run2_fail_exp",   32'(fail_exp), 32'hAA);
`ifdef RAM_BIST_STOP_ON_FAIL_EN
        check("run2_done_lat",   32'(lat), 91);
`else
        check("run2_done_lat",   32'(lat), 131);
`endif
        check("run2_pulses_after", 32'(pulses_after), 0);

        // Clean run from DONE must clear the sticky failure state
        fault = 1'b0;
        run_bist(0, 0, 1'b1);
        check("run3_fail_cleared",  32'(fail_k0), 0);
        check("run3_faddr_cleared", 32'(faddr_k0), 0);
        check("run3_done_lat",      32'(lat), 131);
        check("run3_fail",          32'(fail), 0);
        check("run3_seq",           32'(mon_errs), 0);

        // Reset in cycle 70, then a normal run
        run_bist(0, 70, 1'b0);
        check_zero("midrst");
        run_bist(0, 0, 1'b1);
        check("run5_done_lat", 32'(lat), 131);
        check("run5_fail",     32'(fail), 0);
        check("run5_seq",      32'(mon_errs), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
